// File: rtl/odd_parity_serial_tx_pkg.sv
// Shared definitions for the odd-parity serial transmitter: FSM state encodings
// and the framing bit levels.
package odd_parity_serial_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/odd_parity_serial_tx_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles per serial bit and flags the last
// cycle of each period. restart realigns the count to the first cycle of a bit.
module odd_parity_serial_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end,
    output logic bit_end_next
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_end_q, bit_end_d;

    // Reload at terminal count so the counter never wraps mid-bit.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
        bit_end_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            bit_end_q <= (CLKS_PER_BIT == 1);
        end else begin
            cnt_q     <= cnt_d;
            bit_end_q <= bit_end_d;
        end
    end

    assign bit_end      = bit_end_q;
    assign bit_end_next = bit_end_d;

endmodule

// File: rtl/odd_parity_serial_tx.sv
// Serialises a data word plus its odd parity bit as start, data LSB-first, parity,
// stop, and flags a parity_in that does not make the word odd.
module odd_parity_serial_tx
    import odd_parity_serial_tx_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              parity_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              frame_done,
    output logic              par_err
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              tx_out_q, tx_out_d;
    logic              in_ready_q, in_ready_d;
    logic              tx_busy_q, tx_busy_d;
    logic              frame_done_q, frame_done_d;
    logic              par_err_q, par_err_d;
    logic              restart, bit_end, bit_end_next, accept;

    odd_parity_serial_tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk          (clk),
        .rst          (rst),
        .restart      (restart),
        .bit_end      (bit_end),
        .bit_end_next (bit_end_next)
    );

    assign accept = (state_q == ST_IDLE) && in_valid && in_ready_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        bit_idx_d  = bit_idx_q;
        tx_out_d   = tx_out_q;
        in_ready_d = in_ready_q;
        tx_busy_d  = tx_busy_q;
        par_err_d  = 1'b0;
        restart    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tx_out_d   = STOP_BIT;
                in_ready_d = 1'b1;
                tx_busy_d  = 1'b0;
                if (accept) begin
                    shift_d    = data_in;
                    parity_d   = parity_in;
                    state_d    = ST_START;
                    tx_out_d   = START_BIT;
                    in_ready_d = 1'b0;
                    tx_busy_d  = 1'b1;
                    par_err_d  = (parity_in != ~^data_in);
                    restart    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_out_d  = shift_q[0];
                    shift_d   = shift_q >> 1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_IDX) begin
                        state_d  = ST_PARITY;
                        tx_out_d = parity_q;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        tx_out_d  = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d  = ST_STOP;
                    tx_out_d = STOP_BIT;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d    = ST_IDLE;
                    tx_out_d   = STOP_BIT;
                    in_ready_d = 1'b1;
                    tx_busy_d  = 1'b0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_out_d   = STOP_BIT;
                in_ready_d = 1'b1;
                tx_busy_d  = 1'b0;
            end
        endcase
        // Registered pulse lands on the last STOP cycle, seen one cycle ahead.
        frame_done_d = (state_d == ST_STOP) && bit_end_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_idx_q    <= '0;
            tx_out_q     <= STOP_BIT;
            in_ready_q   <= 1'b1;
            tx_busy_q    <= 1'b0;
            frame_done_q <= 1'b0;
            par_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            tx_out_q     <= tx_out_d;
            in_ready_q   <= in_ready_d;
            tx_busy_q    <= tx_busy_d;
            frame_done_q <= frame_done_d;
            par_err_q    <= par_err_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q  <= shift_d;
        parity_q <= parity_d;
    end

    assign in_ready   = in_ready_q;
    assign tx_out     = tx_out_q;
    assign tx_busy    = tx_busy_q;
    assign frame_done = frame_done_q;
    assign par_err    = par_err_q;

endmodule
